// File: rtl/fetch_unit_if.sv
// Fetch-stage handshake bundle: redirect input, imem request/response, decode hand-off.
// master = fetch unit side, slave = memory/decode/execute side.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_pc_plus4;
  logic [XLEN-1:0] pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_pc_plus4, pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_pc_plus4, pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, DEPTH-entry buffer to decode; a response is visible
// the cycle after rsp_valid; requests stall while the buffer is full; redirect flushes everything.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] fifo_inst_q [DEPTH];
  logic [XLEN-1:0] fifo_pc_q   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic req_vld;
  logic has_space;
  logic accept;
  logic push;
  logic pop;

  assign has_space = count_q < CNT_W'(DEPTH);
  assign accept    = req_vld & bus.imem_req_ready;
  // A redirect cancels both ends of the buffer in the same cycle.
  assign push      = (state_q == S_WAIT) & bus.imem_rsp_valid & ~bus.redirect_valid;
  assign pop       = (count_q != '0) & bus.inst_ready & ~bus.redirect_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (accept) begin
          state_d = bus.redirect_valid ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          state_d = S_REQ;
        end else if (bus.redirect_valid) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (bus.imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    req_vld = (state_q == S_REQ) & has_space;
  end

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + XLEN'(4);
    end
    if (bus.redirect_valid) begin
      pc_d     = bus.redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_inst_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        fifo_inst_q[wr_ptr_q] <= bus.imem_rsp_data;
        fifo_pc_q[wr_ptr_q]   <= req_pc_q;
      end
    end
  end

  assign bus.imem_req_valid = req_vld;
  assign bus.imem_req_addr  = pc_q;
  assign bus.pc             = pc_q;
  assign bus.inst_valid     = (count_q != '0);
  assign bus.inst           = fifo_inst_q[rd_ptr_q];
  assign bus.inst_pc        = fifo_pc_q[rd_ptr_q];
  assign bus.inst_pc_plus4  = fifo_pc_q[rd_ptr_q] + XLEN'(4);
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based memory model, pop recorder, and per-scenario tasks comparing
// the delivered instruction stream against the expected sequential PC stream.
module tb_fetch_unit;
  localparam logic [31:0] MAGIC = 32'hA5A5_0000;
  localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus driven into the main DUT.
  logic        redirect_valid_t = 1'b0;
  logic [31:0] redirect_pc_t    = 32'h0;
  logic        inst_ready_t     = 1'b0;
  logic        mem_ready        = 1'b1;
  logic        mem_rsp_v        = 1'b0;
  logic [31:0] mem_rsp_d        = 32'h0;

  // Memory model controls and in-flight queue.
  int          lat_min   = 1;
  int          lat_max   = 1;
  bit          rnd_ready = 1'b0;
  bit          hold      = 1'b0;
  int          mcyc      = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];

  // Record of every instruction decode accepted.
  logic [31:0] ob_pc   [1024];
  logic [31:0] ob_inst [1024];
  logic [31:0] ob_p4   [1024];
  time         ob_t    [1024];
  int          ob_wr = 0;
  int          rd    = 0;

  fetch_unit_if #(.XLEN(32)) bus ();
  fetch_unit_if #(.XLEN(32)) bus2 ();

  assign bus.redirect_valid = redirect_valid_t;
  assign bus.redirect_pc    = redirect_pc_t;
  assign bus.inst_ready     = inst_ready_t;
  assign bus.imem_req_ready = mem_ready;
  assign bus.imem_rsp_valid = mem_rsp_v;
  assign bus.imem_rsp_data  = mem_rsp_d;

  logic        m2_rsp_v = 1'b0;
  logic [31:0] m2_rsp_d = 32'h0;
  logic        m2_acc   = 1'b0;
  logic [31:0] m2_addr  = 32'h0;

  assign bus2.redirect_valid = 1'b0;
  assign bus2.redirect_pc    = 32'h0;
  assign bus2.inst_ready     = 1'b1;
  assign bus2.imem_req_ready = 1'b1;
  assign bus2.imem_rsp_valid = m2_rsp_v;
  assign bus2.imem_rsp_data  = m2_rsp_d;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(RPC2), .DEPTH(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  // Main memory: returns addr^MAGIC lat cycles after the accepting edge.
  initial forever begin
    @(negedge clk);
    mcyc++;
    mem_rsp_v = 1'b0;
    if (q_due.size() != 0 && q_due[0] <= mcyc) begin
      mem_rsp_v = 1'b1;
      mem_rsp_d = q_addr[0] ^ MAGIC;
      void'(q_due.pop_front());
      void'(q_addr.pop_front());
    end
    mem_ready = hold ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (reset && bus.imem_req_valid && mem_ready) begin
      q_addr.push_back(bus.imem_req_addr);
      q_due.push_back(mcyc + int'($urandom_range(lat_min, lat_max)));
    end
  end

  // Second memory: fixed one-cycle latency, always ready.
  initial forever begin
    @(negedge clk);
    m2_rsp_v = m2_acc;
    m2_rsp_d = m2_addr ^ MAGIC;
    m2_acc   = reset && bus2.imem_req_valid;
    m2_addr  = bus2.imem_req_addr;
  end

  initial forever begin
    @(negedge clk);
    if (reset && !redirect_valid_t && inst_ready_t && bus.inst_valid) begin
      ob_pc[ob_wr % 1024]   = bus.inst_pc;
      ob_inst[ob_wr % 1024] = bus.inst;
      ob_p4[ob_wr % 1024]   = bus.inst_pc_plus4;
      ob_t[ob_wr % 1024]    = $time;
      ob_wr++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset            = 1'b0;
    redirect_valid_t = 1'b0;
    hold             = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 30 && q_due.size() != 0; i++) step();
    reset = 1'b1;
    rd    = ob_wr;
  endtask

  task automatic test_reset();
    inst_ready_t = 1'b0;
    rnd_ready    = 1'b0;
    do_reset();
    @(negedge clk);
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
    checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_req_valid: got %b want 1", bus.imem_req_valid); end
    checks++; if (bus.imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want %h", bus.imem_req_addr, 32'h0); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid); end
    checks++; if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin errors++; $display("FAIL reset_head: inst %h pc %h want 0 0", bus.inst, bus.inst_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    time         prev_t;
    inst_ready_t = 1'b1;
    lat_min = 1; lat_max = 1; rnd_ready = 1'b0;
    do_reset();
    e = 32'h0; prev_t = 0;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 50 && ob_wr == rd; w++) step();
      checks++;
      if (ob_wr == rd) begin
        errors++; $display("FAIL stream_timeout: pop %0d not seen, required within budget", k);
      end else begin
        checks++; if (ob_pc[rd % 1024] !== e) begin errors++; $display("FAIL stream_pc: got %h want %h", ob_pc[rd % 1024], e); end
        checks++; if (ob_inst[rd % 1024] !== (e ^ MAGIC)) begin errors++; $display("FAIL stream_inst: got %h want %h", ob_inst[rd % 1024], e ^ MAGIC); end
        checks++; if (ob_p4[rd % 1024] !== e + 32'd4) begin errors++; $display("FAIL stream_plus4: got %h want %h", ob_p4[rd % 1024], e + 32'd4); end
        if (k > 0) begin
          checks++; if (ob_t[rd % 1024] - prev_t != 20) begin errors++; $display("FAIL stream_rate: gap %0t want 20", ob_t[rd % 1024] - prev_t); end
        end
        prev_t = ob_t[rd % 1024];
        rd++;
        e += 32'd4;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    inst_ready_t = 1'b0;
    lat_min = 1; lat_max = 1; rnd_ready = 1'b0;
    do_reset();
    repeat (10) step();
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b want 0", bus.imem_req_valid); end
    checks++; if (bus.pc !== 32'h8) begin errors++; $display("FAIL bp_pc: got %h want %h", bus.pc, 32'h8); end
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin errors++; $display("FAIL bp_head: valid %b pc %h want 1 0", bus.inst_valid, bus.inst_pc); end
    step();
    inst_ready_t = 1'b1;
    rd = ob_wr;
    e  = 32'h0;
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 50 && ob_wr == rd; w++) step();
      checks++;
      if (ob_wr == rd) begin
        errors++; $display("FAIL bp_timeout: pop %0d not seen, required within budget", k);
      end else begin
        checks++; if (ob_pc[rd % 1024] !== e || ob_inst[rd % 1024] !== (e ^ MAGIC)) begin
          errors++; $display("FAIL bp_pop: pc %h inst %h want %h %h", ob_pc[rd % 1024], ob_inst[rd % 1024], e, e ^ MAGIC);
        end
        rd++;
        e += 32'd4;
      end
    end
  endtask

  task automatic test_redirect();
    bit          found;
    int          lat;
    logic [31:0] e;
    for (int it = 0; it < 2; it++) begin
      lat = (it == 0) ? 3 : 1;
      inst_ready_t = 1'b0;
      lat_min = lat; lat_max = lat; rnd_ready = 1'b0;
      do_reset();
      found = 1'b0;
      for (int w = 0; w < 50 && !found; w++) begin
        @(negedge clk);
        if (bus.imem_req_valid && bus.imem_req_addr == 32'h4) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL redir_setup lat%0d: request for 0x4 not seen", lat); end
      step();
      redirect_valid_t = 1'b1;
      redirect_pc_t    = 32'h20;
      step();
      redirect_valid_t = 1'b0;
      @(negedge clk);
      checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush lat%0d: inst_valid %b want 0", lat, bus.inst_valid); end
      checks++; if (bus.pc !== 32'h20) begin errors++; $display("FAIL redir_pc lat%0d: got %h want %h", lat, bus.pc, 32'h20); end
      checks++; if (bus.imem_req_valid !== (lat == 1)) begin
        errors++; $display("FAIL redir_drop lat%0d: req_valid %b want %b", lat, bus.imem_req_valid, lat == 1);
      end
      step();
      inst_ready_t = 1'b1;
      rd = ob_wr;
      e  = 32'h20;
      for (int k = 0; k < 2; k++) begin
        for (int w = 0; w < 50 && ob_wr == rd; w++) step();
        checks++;
        if (ob_wr == rd) begin
          errors++; $display("FAIL redir_timeout lat%0d: pop %0d not seen", lat, k);
        end else begin
          checks++; if (ob_pc[rd % 1024] !== e || ob_inst[rd % 1024] !== (e ^ MAGIC)) begin
            errors++; $display("FAIL redir_pop lat%0d: pc %h inst %h want %h %h", lat, ob_pc[rd % 1024], ob_inst[rd % 1024], e, e ^ MAGIC);
          end
          rd++;
          e += 32'd4;
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    int          k;
    inst_ready_t = 1'b0;
    do_reset();
    e = RPC2;
    k = 0;
    for (int c = 0; c < 40 && k < 3; c++) begin
      @(negedge clk);
      if (bus2.inst_valid) begin
        checks++; if (bus2.inst_pc !== e) begin errors++; $display("FAIL wrap_pc: got %h want %h", bus2.inst_pc, e); end
        checks++; if (bus2.inst !== (e ^ MAGIC)) begin errors++; $display("FAIL wrap_inst: got %h want %h", bus2.inst, e ^ MAGIC); end
        checks++; if (bus2.inst_pc_plus4 !== e + 32'd4) begin errors++; $display("FAIL wrap_plus4: got %h want %h", bus2.inst_pc_plus4, e + 32'd4); end
        e += 32'd4;
        k++;
      end
    end
    checks++; if (k != 3) begin errors++; $display("FAIL wrap_count: got %0d pops want 3", k); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    inst_ready_t = 1'b0;
    lat_min = 8; lat_max = 8; rnd_ready = 1'b0;
    do_reset();
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    hold  = 1'b1;
    step();
    step();
    reset = 1'b1;
    for (int w = 0; w < 30 && q_due.size() != 0; w++) step();
    checks++; if (q_due.size() != 0) begin errors++; $display("FAIL rmid_late_rsp: %0d responses still pending, want 0", q_due.size()); end
    step();
    @(negedge clk);
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rmid_ignored: inst_valid %b want 0", bus.inst_valid); end
    checks++; if (bus.pc !== 32'h0 || bus.imem_req_valid !== 1'b1) begin
      errors++; $display("FAIL rmid_state: pc %h req_valid %b want 0 1", bus.pc, bus.imem_req_valid);
    end
    step();
    lat_min = 1; lat_max = 1;
    hold = 1'b0;
    inst_ready_t = 1'b1;
    rd = ob_wr;
    e  = 32'h0;
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 50 && ob_wr == rd; w++) step();
      checks++;
      if (ob_wr == rd) begin
        errors++; $display("FAIL rmid_timeout: pop %0d not seen", k);
      end else begin
        checks++; if (ob_pc[rd % 1024] !== e || ob_inst[rd % 1024] !== (e ^ MAGIC)) begin
          errors++; $display("FAIL rmid_pop: pc %h inst %h want %h %h", ob_pc[rd % 1024], ob_inst[rd % 1024], e, e ^ MAGIC);
        end
        rd++;
        e += 32'd4;
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    int          pops;
    inst_ready_t = 1'b0;
    lat_min = 1; lat_max = 3; rnd_ready = 1'b1;
    do_reset();
    e = 32'h0;
    pops = 0;
    for (int c = 0; c < 420; c++) begin
      step();
      while (rd != ob_wr) begin
        checks++; if (ob_pc[rd % 1024] !== e) begin errors++; $display("FAIL rand_pc: got %h want %h", ob_pc[rd % 1024], e); end
        checks++; if (ob_inst[rd % 1024] !== (e ^ MAGIC)) begin errors++; $display("FAIL rand_inst: got %h want %h", ob_inst[rd % 1024], e ^ MAGIC); end
        checks++; if (ob_p4[rd % 1024] !== e + 32'd4) begin errors++; $display("FAIL rand_plus4: got %h want %h", ob_p4[rd % 1024], e + 32'd4); end
        e += 32'd4;
        rd++;
        pops++;
      end
      if (c >= 400) begin
        redirect_valid_t = 1'b0;
        inst_ready_t     = 1'b1;
      end else begin
        inst_ready_t = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 19) == 0) begin
          redirect_valid_t = 1'b1;
          redirect_pc_t    = $urandom() & 32'hFFFF_FFFC;
          e                = redirect_pc_t;
        end else begin
          redirect_valid_t = 1'b0;
        end
      end
    end
    checks++; if (pops < 20) begin errors++; $display("FAIL rand_progress: %0d pops want at least 20", pops); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
